his_acq_sequencer: RTL and testbench
====================================

// Module: his_acq_sequencer
// PURPOSE
//   Sequences one histogram frame into hisBuilderFSM.
//   - Clears the builder, then waits for a laser trigger per acquisition.
//   - Scans the pixel slots in fixed ascending order and grants each pixel's TDC word through a valid/ready handshake.
//   - Substitutes the null code 0 for silent pixels, so the builder always sees PIXEL_NUM words per acquisition.
//   - After ACQ_NUM acquisitions it drains the builder pipeline and pulses frame_done.
// PARAMETERS
//   PIXEL_NUM     6   pixel slots scanned per acquisition
//   ACQ_NUM       2   acquisitions (laser shots) per frame
//   NP            10  TDC word width (matches `Np)
//   WAIT_MAX      4   max cycles a slot waits for valid before a null write (>=1)
//   DRAIN_CYCLES  4   idle cycles after the last write before frame_done (>=1)
// PORTS
//   clk          in   1             system clock
//   res          in   1             synchronous reset, active-high
//   start        in   1             begin frame; honoured only in IDLE
//   abort        in   1             cancel frame; honoured in any non-IDLE state
//   laser_trig   in   1             shot sync pulse; starts one acquisition scan
//   pix_valid    in   PIXEL_NUM     per-pixel TDC word valid
//   pix_data     in   PIXEL_NUM*NP  per-pixel TDC words; pixel i at [i*NP +: NP]
//   pix_ready    out  PIXEL_NUM     per-pixel grant; at most one bit high
//   hb_res       out  1             builder clear, active-high, one-cycle pulse
//   hb_wr_en     out  1             builder write strobe (drives wrEn)
//   hb_data      out  NP            builder write word (drives data)
//   busy         out  1             high in every state except IDLE
//   frame_done   out  1             one-cycle pulse at frame completion
//   trig_overrun out  1             sticky: laser_trig arrived while not in WAIT_TRIG
// BEHAVIOUR
//   Reset and priority
//   - res: state=IDLE; slot, wait and acq counters = 0; all outputs 0. res has highest priority.
//   - Next is abort (non-IDLE -> IDLE next cycle), then normal transitions.
//   States
//   - IDLE: start=1 -> CLEAR; clear trig_overrun.
//   - CLEAR: hb_res=1 for exactly this cycle; acq_cnt=0 -> WAIT_TRIG.
//   - WAIT_TRIG: laser_trig=1 -> SCAN with slot=0, wait=0.
//   - SCAN:
//     - pix_ready[slot] = pix_valid[slot] (combinational, SCAN only); all other ready bits are 0.
//     - Handshake in cycle t -> hb_wr_en=1 and hb_data=pix_data[slot] in cycle t+1 (registered); then slot++ and wait=0.
//     - No valid: wait++. In the cycle wait==WAIT_MAX-1 with still no valid, register a null write (hb_wr_en=1, hb_data=0) and slot++.
//     - A pixel presenting data 0 is written as 0; the builder treats 0 as no-photon.
//     - After slot PIXEL_NUM-1 is written: if acq_cnt==ACQ_NUM-1 -> DRAIN, else acq_cnt++ -> WAIT_TRIG.
//   - DRAIN: hb_wr_en=0 for DRAIN_CYCLES cycles -> DONE.
//   - DONE: frame_done=1 for one cycle -> IDLE.
//   Output and invariants
//   - hb_data = 0 whenever hb_wr_en = 0.
//   - Each completed frame produces exactly PIXEL_NUM*ACQ_NUM hb_wr_en pulses, in slot order 0..PIXEL_NUM-1 per acquisition.
//   - frame_done is high exactly DRAIN_CYCLES+1 cycles after the last hb_wr_en cycle.
//   Boundaries
//   - WAIT_MAX=1: every slot takes one cycle; valid in that cycle is granted, otherwise a null write.
//   - laser_trig outside WAIT_TRIG is ignored for sequencing; sets trig_overrun (except in IDLE).
//   - start outside IDLE is ignored. abort and start in the same IDLE cycle: start wins (abort is meaningless in IDLE).
//   - abort mid-SCAN: no further writes, no frame_done, pix_ready=0 the next cycle. A grant in the abort cycle still produces its write.
//   - abort does not clear trig_overrun.
// TESTING
//   T1 Nominal frame
//      - Stimulus: all pix_valid=1, pix_data[i]=100+i; start, then two laser_trig pulses.
//      - Response: one hb_res pulse; 12 writes, 100..105 twice, each scan on 6 consecutive cycles; frame_done 5 cycles after the last write.
//   T2 Silent pixel
//      - Stimulus: pixel 2 valid=0, other pixels as T1.
//      - Response: slot 2 write has hb_data=0, issued 4 cycles after slot 1's write; pix_ready[2] is never high.
//   T3 Delayed pixel
//      - Stimulus: pixel 4 raises valid with data 777 on its 3rd wait cycle.
//      - Response: write 777 (not null); slot 5 follows on schedule.
//   T4 Trigger overrun
//      - Stimulus: laser_trig pulse during SCAN.
//      - Response: trig_overrun=1 and stays high; the write sequence is unchanged; the next start clears it.
//   T5 Abort and restart
//      - Stimulus: abort at slot 3 of acquisition 0, then a new start.
//      - Response: busy=0 the next cycle; no writes after the abort, except a write already granted in the abort cycle; no frame_done; the new frame gives a fresh hb_res and 12 writes.
//   T6 Reset and start mid-frame
//      - Stimulus: res=1 mid-SCAN; separately, start pulsed while busy.
//      - Response: on res, all outputs 0 the next cycle and state IDLE; the busy-time start has no effect on write count or timing.

Source files
------------

// File: rtl/his_acq_if.sv
// Pixel-side valid/ready handshake and histogram-builder write bus of the acquisition sequencer.
interface his_acq_if #(
  parameter int PIXEL_NUM = 6,
  parameter int NP        = 10
);
  logic [PIXEL_NUM-1:0]    pix_valid;
  logic [PIXEL_NUM*NP-1:0] pix_data;
  logic [PIXEL_NUM-1:0]    pix_ready;
  logic                    hb_res;
  logic                    hb_wr_en;
  logic [NP-1:0]           hb_data;

  modport master (
    input  pix_valid, pix_data,
    output pix_ready, hb_res, hb_wr_en, hb_data
  );

  modport slave (
    output pix_valid, pix_data,
    input  pix_ready, hb_res, hb_wr_en, hb_data
  );
endinterface

// File: rtl/his_acq_sequencer.sv
// Frame sequencer for hisBuilderFSM: clear, per-shot ascending pixel scan with
// timeout-driven null words, then pipeline drain and a frame_done pulse.
module his_acq_sequencer #(
  parameter int PIXEL_NUM    = 6,
  parameter int ACQ_NUM      = 2,
  parameter int NP           = 10,
  parameter int WAIT_MAX     = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic        abort,
  input  logic        laser_trig,
  his_acq_if.master   bus,
  output logic        busy,
  output logic        frame_done,
  output logic        trig_overrun
);

  localparam int SLOT_W  = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
  localparam int ACQ_W   = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam int WAIT_W  = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_TRIG,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ACQ_W-1:0]    acq_q, acq_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                wr_en_q, wr_en_d;
  logic [NP-1:0]       data_q, data_d;
  logic                ovr_q, ovr_d;

  logic                sel_valid;
  logic [NP-1:0]       sel_data;
  logic                grant;
  logic [PIXEL_NUM-1:0] pix_ready_c;

  // Mux of the pixel currently addressed by the scan slot.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < PIXEL_NUM; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        sel_valid = bus.pix_valid[i];
        sel_data  = bus.pix_data[i*NP +: NP];
      end
    end
  end

  assign grant = (state_q == S_SCAN) && sel_valid;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    wait_d      = wait_q;
    acq_d       = acq_q;
    drain_d     = drain_q;
    wr_en_d     = 1'b0;
    data_d      = '0;
    ovr_d       = ovr_q;
    pix_ready_c = '0;

    if (laser_trig && (state_q != S_IDLE) && (state_q != S_WAIT_TRIG)) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          ovr_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        acq_d   = '0;
        state_d = S_WAIT_TRIG;
      end
      S_WAIT_TRIG: begin
        if (laser_trig) begin
          state_d = S_SCAN;
          slot_d  = '0;
          wait_d  = '0;
        end
      end
      S_SCAN: begin
        for (int i = 0; i < PIXEL_NUM; i++) begin
          if (slot_q == SLOT_W'(i)) pix_ready_c[i] = bus.pix_valid[i];
        end
        // A slot closes either on its handshake or on the last allowed wait cycle.
        if (sel_valid || (wait_q == WAIT_W'(WAIT_MAX - 1))) begin
          wr_en_d = 1'b1;
          data_d  = sel_valid ? sel_data : '0;
          wait_d  = '0;
          if (slot_q == SLOT_W'(PIXEL_NUM - 1)) begin
            slot_d = '0;
            if (acq_q == ACQ_W'(ACQ_NUM - 1)) begin
              state_d = S_DRAIN;
              drain_d = '0;
            end else begin
              acq_d   = acq_q + 1'b1;
              state_d = S_WAIT_TRIG;
            end
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // First DRAIN cycle still carries the last registered write.
        if (drain_q == DRAIN_W'(DRAIN_CYCLES)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort keeps a write already granted this cycle but drops a pending null write.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      if (!grant) begin
        wr_en_d = 1'b0;
        data_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      wait_q  <= '0;
      acq_q   <= '0;
      drain_q <= '0;
      wr_en_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      wait_q  <= wait_d;
      acq_q   <= acq_d;
      drain_q <= drain_d;
      wr_en_q <= wr_en_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign bus.pix_ready = pix_ready_c;
  assign bus.hb_res    = (state_q == S_CLEAR);
  assign bus.hb_wr_en  = wr_en_q;
  assign bus.hb_data   = wr_en_q ? data_q : '0;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DONE);
  assign trig_overrun  = ovr_q;

endmodule

// File: tb/tb_his_acq_sequencer.sv
// Scoreboard bench for his_acq_sequencer: a timeline model of each frame predicts
// writes, pulses and per-cycle status; a negedge monitor pops and compares.
module tb_his_acq_sequencer;
  localparam int PIX = 6;
  localparam int ACQ = 2;
  localparam int NP  = 10;
  localparam int WM  = 4;
  localparam int DC  = 4;

  logic clk = 1'b0;
  logic res, start, abort, laser_trig;
  logic busy, frame_done, trig_overrun;

  his_acq_if #(.PIXEL_NUM(PIX), .NP(NP)) bus ();

  his_acq_sequencer #(
    .PIXEL_NUM(PIX), .ACQ_NUM(ACQ), .NP(NP), .WAIT_MAX(WM), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .res(res), .start(start), .abort(abort), .laser_trig(laser_trig),
    .bus(bus), .busy(busy), .frame_done(frame_done), .trig_overrun(trig_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int data; int at; } wr_t;
  wr_t wr_q[$];
  int  res_q[$];
  int  done_q[$];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic [PIX-1:0] exp_ready = '0;
  logic exp_busy = 1'b0;
  logic exp_ovr = 1'b0;
  logic ovr_cur = 1'b0;

  // dly >= WM means the pixel stays silent for that acquisition
  int dly[ACQ][PIX];
  int dat[ACQ][PIX];

  always @(negedge clk) begin : mon
    wr_t w;
    int r;
    if (chk_en) begin
      if (bus.hb_wr_en === 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d data=%0d required=no write", cyc, bus.hb_data);
        end else begin
          w = wr_q.pop_front();
          if (bus.hb_data !== NP'(w.data) || cyc != w.at) begin
            failures++;
            $display("FAIL write actual data=%0d cyc=%0d required data=%0d cyc=%0d",
                     bus.hb_data, cyc, w.data, w.at);
          end
        end
      end else begin
        checks++;
        if (bus.hb_wr_en !== 1'b0 || bus.hb_data !== '0) begin
          failures++;
          $display("FAIL idle_bus cyc=%0d actual wr_en=%b data=%0d required wr_en=0 data=0",
                   cyc, bus.hb_wr_en, bus.hb_data);
        end
      end
      if (bus.hb_res !== 1'b0) begin
        checks++;
        if (res_q.size() == 0) begin
          failures++;
          $display("FAIL hb_res cyc=%0d actual=%b required=0", cyc, bus.hb_res);
        end else begin
          r = res_q.pop_front();
          if (bus.hb_res !== 1'b1 || cyc != r) begin
            failures++;
            $display("FAIL hb_res actual cyc=%0d required cyc=%0d", cyc, r);
          end
        end
      end
      if (frame_done !== 1'b0) begin
        checks++;
        if (done_q.size() == 0) begin
          failures++;
          $display("FAIL frame_done cyc=%0d actual=%b required=0", cyc, frame_done);
        end else begin
          r = done_q.pop_front();
          if (frame_done !== 1'b1 || cyc != r) begin
            failures++;
            $display("FAIL frame_done actual cyc=%0d required cyc=%0d", cyc, r);
          end
        end
      end
      checks++;
      if (bus.pix_ready !== exp_ready) begin
        failures++;
        $display("FAIL pix_ready cyc=%0d actual=%b required=%b", cyc, bus.pix_ready, exp_ready);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL busy cyc=%0d actual=%b required=%b", cyc, busy, exp_busy);
      end
      checks++;
      if (trig_overrun !== exp_ovr) begin
        failures++;
        $display("FAIL trig_overrun cyc=%0d actual=%b required=%b", cyc, trig_overrun, exp_ovr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nominal();
    for (int a = 0; a < ACQ; a++)
      for (int i = 0; i < PIX; i++) begin
        dly[a][i] = 0;
        dat[a][i] = 100 + i;
      end
  endtask

  task automatic set_random();
    for (int a = 0; a < ACQ; a++)
      for (int i = 0; i < PIX; i++) begin
        dly[a][i] = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, WM + 1));
        dat[a][i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
      end
  endtask

  // mode 0: full frame, 1: abort at acq 0 slot 3, 2: reset at acq 0 slot 3
  task automatic run_frame(input int mode, input bit force_spur);
    int c0, c, avail, sc, w_cyc, dn, last_busy, stop, lim, a_in;
    int tt[ACQ];
    int ee[ACQ];
    int ss[ACQ][PIX];
    int dd[ACQ][PIX];
    bit st, ab, trig, spur, rs;
    logic [PIX-1:0] v, er;
    logic [PIX*NP-1:0] pd;
    wr_t w;

    c0 = cyc;
    avail = c0 + 2;
    for (int a = 0; a < ACQ; a++) begin
      tt[a] = avail + int'($urandom_range(0, 2));
      sc = tt[a] + 1;
      for (int i = 0; i < PIX; i++) begin
        ss[a][i] = sc;
        dd[a][i] = (dly[a][i] < WM) ? dly[a][i] + 1 : WM;
        sc += dd[a][i];
      end
      ee[a] = sc - 1;
      avail = ee[a] + 1;
    end
    w_cyc = ee[ACQ-1] + 1;
    dn = w_cyc + DC + 1;

    res_q.push_back(c0 + 1);
    if (mode == 0) begin
      last_busy = dn;
      lim = PIX - 1;
      done_q.push_back(dn);
    end else begin
      last_busy = ss[0][3];
      lim = (mode == 1) ? 3 : 2;
    end
    stop = last_busy + 1;
    for (int a = 0; a < ACQ; a++)
      for (int i = 0; i < PIX; i++)
        if (mode == 0 || (a == 0 && i <= lim)) begin
          w.data = (dly[a][i] < WM) ? dat[a][i] : 0;
          w.at = ss[a][i] + dd[a][i];
          wr_q.push_back(w);
        end

    while (cyc <= stop + 2) begin
      c = cyc;
      st = (c == c0) || (c > c0 && c < last_busy && $urandom_range(0, 7) == 0);
      ab = ((c == c0 || c >= stop) && $urandom_range(0, 1) == 1) || (mode == 1 && c == last_busy);
      rs = (mode == 2 && c == last_busy);
      a_in = -1;
      for (int a = 0; a < ACQ; a++)
        if (c > tt[a] && c <= ee[a] && c <= last_busy) a_in = a;
      trig = 1'b0;
      for (int a = 0; a < ACQ; a++)
        if (c == tt[a] && c < last_busy) trig = 1'b1;
      spur = 1'b0;
      if (c > c0 && c < last_busy && (c == c0 + 1 || a_in >= 0 || (mode == 0 && c >= w_cyc)))
        spur = (force_spur && c == ss[0][1]) || ($urandom_range(0, 9) == 0);
      trig = trig | spur;

      v = PIX'($urandom);
      pd = {$urandom, $urandom};
      er = '0;
      if (a_in >= 0) begin
        for (int i = 0; i < PIX; i++) begin
          v[i] = (dly[a_in][i] < WM) && (c >= ss[a_in][i] + dly[a_in][i]);
          pd[i*NP +: NP] = NP'(dat[a_in][i]);
        end
        for (int i = 0; i < PIX; i++)
          if (c >= ss[a_in][i] && c < ss[a_in][i] + dd[a_in][i]) er[i] = v[i];
      end

      start = st;
      abort = ab;
      res = rs;
      laser_trig = trig;
      bus.pix_valid = v;
      bus.pix_data = pd;
      exp_ready = er;
      exp_busy = (c > c0 && c <= last_busy);
      exp_ovr = ovr_cur;

      if (c == c0) ovr_cur = 1'b0;
      if (spur) ovr_cur = 1'b1;
      if (rs) ovr_cur = 1'b0;
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    res = 1'b0;
    laser_trig = 1'b0;

    checks++;
    if (wr_q.size() != 0 || res_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL frame_leftover mode=%0d actual writes=%0d res=%0d done=%0d required all 0",
               mode, wr_q.size(), res_q.size(), done_q.size());
    end
    wr_q.delete();
    res_q.delete();
    done_q.delete();
  endtask

  initial begin
    res = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    laser_trig = 1'b0;
    bus.pix_valid = '0;
    bus.pix_data = '0;
    tick();
    chk_en = 1'b1;
    tick();
    res = 1'b0;
    tick();
    tick();

    set_nominal();
    run_frame(0, 1'b0);

    set_nominal();
    for (int a = 0; a < ACQ; a++) dly[a][2] = WM;
    run_frame(0, 1'b0);

    set_nominal();
    dly[0][4] = 2;
    dat[0][4] = 777;
    run_frame(0, 1'b0);

    set_random();
    run_frame(0, 1'b1);

    set_nominal();
    run_frame(1, 1'b1);
    set_nominal();
    run_frame(0, 1'b0);

    set_random();
    dly[0][3] = 0;
    run_frame(2, 1'b1);
    set_nominal();
    run_frame(0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      set_random();
      if (k % 5 == 4) begin
        dly[0][3] = 0;
        run_frame((k / 5) % 2 + 1, 1'b1);
      end else begin
        run_frame(0, k[0]);
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
